pll_reset_ctrl: RTL and testbench
=================================

# pll_reset_ctrl

Reset sequencer on the PLL control interface, i.e. the consumer end of the PLL's `rst`/`locked` pair. It runs on the free-running reference clock and does three things:
- drives a timed reset pulse into the PLL;
- waits for lock (with timeout and retry), then requires lock to stay stable before releasing the system reset;
- detects loss of lock during operation and re-runs the whole sequence.

It sits between the board reset and every block clocked from the PLL outputs.

## Interface

Parameters:
- `RST_PULSE_CYCLES`, 16: cycles `pll_rst` is held high per attempt (≥2).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before release (≥1).
- `LOCK_TIMEOUT_CYCLES`, 65536: maximum cycles in WAIT_LOCK before retrying (≥2).

Ports:
- `refclk` in 1: free-running 50 MHz reference clock. This is the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `locked` in 1: PLL lock indicator, asynchronous to `refclk`.
- `relock_req` in 1: single-cycle request to force a full PLL re-lock.
- `pll_rst` out 1: active-high reset to the PLL.
- `sys_rst` out 1: active-high reset to downstream logic.
- `ready` out 1: high only in RUN; always equals `!sys_rst`.
- `timeout_cnt` out 8: number of lock timeouts; saturates at 255.
- `loss_cnt` out 8: number of lock losses while in RUN; saturates at 255.

## Operation

- `locked` passes through a 2-flop synchronizer clocked by `refclk`; its output is `locked_s`. The synchronizer flops reset to 0.
- One shared counter `cnt`:
  - width is clog2 of the largest parameter;
  - cleared to 0 on every state entry;
  - in a counting state, each edge either transitions (when `cnt == N-1`) or increments `cnt`.
- States:
  - **PLL_RST**: `pll_rst=1`. On the edge where `cnt == RST_PULSE_CYCLES-1`, go to WAIT_LOCK.
  - **WAIT_LOCK**: `pll_rst=0`.
    - If `locked_s=1`, go to STABLE.
    - Otherwise, on the edge where `cnt == LOCK_TIMEOUT_CYCLES-1`, go to PLL_RST and increment `timeout_cnt` (saturating).
  - **STABLE**:
    - If `locked_s=0`, return to WAIT_LOCK with `cnt` cleared. This is not counted as a loss.
    - Otherwise, on the edge where `cnt == LOCK_STABLE_CYCLES-1`, go to RUN.
  - **RUN**: `sys_rst=0`, `ready=1`. If `locked_s=0`, go to PLL_RST and increment `loss_cnt` (saturating).
- `relock_req` has the highest priority in every state. It forces PLL_RST with `cnt` cleared. It does not change either counter, even if lock drops in the same cycle.
- In PLL_RST, a new `relock_req` restarts the pulse, so `pll_rst` stays high for a full `RST_PULSE_CYCLES` from the latest request.
- Retries are unlimited. There is no failure state.
- `sys_rst` is high in every state except RUN.

## Timing

- While `rst` is asserted (asynchronously):
  - state = PLL_RST, `cnt=0`;
  - `pll_rst=1`, `sys_rst=1`, `ready=0`;
  - `timeout_cnt=0`, `loss_cnt=0`, synchronizer flops = 0.
- All outputs are registered and change on the same `refclk` edge as the state transition that causes them. There are no combinational paths from inputs to outputs.
- Nominal release, with `locked` high throughout and edges counted from the first edge after `rst` deasserts:
  - `pll_rst` falls at edge `RST_PULSE_CYCLES`;
  - STABLE is entered at edge `RST_PULSE_CYCLES+1`;
  - `sys_rst` falls and `ready` rises at edge `RST_PULSE_CYCLES+1+LOCK_STABLE_CYCLES`.
- Lock loss in RUN: `locked` falling reaches `locked_s` 2 edges later. `sys_rst` and `pll_rst` rise on the next edge, i.e. 3 edges after the fall in the worst case.
- Timeout: a full timeout attempt lasts `RST_PULSE_CYCLES + LOCK_TIMEOUT_CYCLES` cycles, from `pll_rst` rising to `pll_rst` rising again.
- Asserting `rst` mid-sequence returns to the reset values immediately, including clearing both counters.
- Counter saturation: at 255, further events leave the value at 255.

## Test plan

Use `RST_PULSE_CYCLES=4`, `LOCK_STABLE_CYCLES=8`, `LOCK_TIMEOUT_CYCLES=32`.

- **Nominal**: tie `locked=1` and release `rst`.
  - Required: `pll_rst` falls at edge 4; `sys_rst` falls and `ready` rises at edge 13; both counters stay 0.
- **Lock glitch in STABLE**: `locked` drops for 1 cycle mid-STABLE.
  - Required: back to WAIT_LOCK; the full 8 stable cycles are required again after `locked_s` returns; `loss_cnt` stays 0; `pll_rst` stays 0.
- **Timeout**: hold `locked=0`.
  - Required: `pll_rst` pulses high for 4 cycles every 36 cycles; `timeout_cnt` reads 1, 2, 3 after successive pulses; `sys_rst` stays 1.
  - Extension: hold `locked=0` for 300 attempts; required: `timeout_cnt` sticks at 255.
- **Loss in RUN**: from RUN, drop `locked`.
  - Required: `sys_rst` and `pll_rst` rise 3 edges later; `loss_cnt=1`.
  - Then re-assert `locked`; required: `ready` returns after the full sequence.
- **`relock_req`**:
  - Pulse it in RUN; required: PLL_RST is entered on the next edge and the counters are unchanged.
  - Pulse it again 2 cycles into PLL_RST; required: `pll_rst` is high for 6 cycles in total.
- **Async reset**: assert `rst` mid-STABLE, between clock edges, after `timeout_cnt=2`.
  - Required: all outputs take their reset values immediately, without waiting for a clock edge, and `timeout_cnt=0`.

Source files
------------

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for lock with timeout/retry,
// qualifies lock stability, then releases the system reset and watches for lock loss.
module pll_reset_ctrl #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [7:0] timeout_cnt,
    output logic [7:0] loss_cnt
);

    localparam int MAX_AB = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ?
                            RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_P  = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int CNT_W  = $clog2(MAX_P);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             locked_p0;
    logic             locked_p1;
    logic             locked_s;
    logic             timeout_inc;
    logic             loss_inc;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign locked_s = locked_p1;

    // Stage 0/1: two-flop synchronizer for the asynchronous lock indicator
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            locked_p0 <= 1'b0;
            locked_p1 <= 1'b0;
        end else begin
            locked_p0 <= locked;
            locked_p1 <= locked_p0;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + CNT_W'(1);
        timeout_inc = 1'b0;
        loss_inc    = 1'b0;
        if (relock_req) begin
            state_nxt = S_PLL_RST;
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_PLL_RST: begin
                    if (cnt == RST_LAST) begin
                        state_nxt = S_WAIT_LOCK;
                        cnt_nxt   = '0;
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_nxt = S_STABLE;
                        cnt_nxt   = '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state_nxt   = S_PLL_RST;
                        cnt_nxt     = '0;
                        timeout_inc = 1'b1;
                    end
                end
                S_STABLE: begin
                    // A lock dropout here only restarts qualification; it is not a loss
                    if (!locked_s) begin
                        state_nxt = S_WAIT_LOCK;
                        cnt_nxt   = '0;
                    end else if (cnt == STABLE_LAST) begin
                        state_nxt = S_RUN;
                        cnt_nxt   = '0;
                    end
                end
                S_RUN: begin
                    cnt_nxt = '0;
                    if (!locked_s) begin
                        state_nxt = S_PLL_RST;
                        loss_inc  = 1'b1;
                    end
                end
                default: begin
                    state_nxt = S_PLL_RST;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Stage 2: state, counter and outputs all registered from the next-state decode
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state       <= S_PLL_RST;
            cnt         <= '0;
            pll_rst     <= 1'b1;
            sys_rst     <= 1'b1;
            ready       <= 1'b0;
            timeout_cnt <= 8'd0;
            loss_cnt    <= 8'd0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pll_rst <= (state_nxt == S_PLL_RST);
            sys_rst <= (state_nxt != S_RUN);
            ready   <= (state_nxt == S_RUN);
            if (timeout_inc) begin
                timeout_cnt <= sat_inc(timeout_cnt);
            end
            if (loss_inc) begin
                loss_cnt <= sat_inc(loss_cnt);
            end
        end
    end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed bench for pll_reset_ctrl with short pulse/stable/timeout parameters.
module tb_pll_reset_ctrl;

    logic       refclk;
    logic       rst;
    logic       locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic [7:0] timeout_cnt;
    logic [7:0] loss_cnt;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    pll_reset_ctrl #(
        .RST_PULSE_CYCLES   (4),
        .LOCK_STABLE_CYCLES (8),
        .LOCK_TIMEOUT_CYCLES(32)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .locked     (locked),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .timeout_cnt(timeout_cnt),
        .loss_cnt   (loss_cnt)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       locked;
        logic       relock;
        logic       pll_rst;
        logic       sys_rst;
        logic       ready;
        logic [7:0] tcnt;
        logic [7:0] lcnt;
    } vec_t;

    vec_t nom [14];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s edge=%0d got=%0d expected=%0d", name, edge_n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        edge_n++;
        @(negedge refclk);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Reset applied and released at a falling edge, so edge 1 is the first rising edge after release
    task automatic do_reset(input logic lk);
        @(negedge refclk);
        rst        = 1'b1;
        locked     = lk;
        relock_req = 1'b0;
        @(negedge refclk);
        @(negedge refclk);
        rst    = 1'b0;
        edge_n = 0;
    endtask

    function automatic vec_t mk(input logic lk, input logic rq, input logic p, input logic s,
                                input logic r, input logic [7:0] t, input logic [7:0] l);
        vec_t v;
        v.locked = lk; v.relock = rq; v.pll_rst = p; v.sys_rst = s;
        v.ready = r; v.tcnt = t; v.lcnt = l;
        return v;
    endfunction

    initial begin
        int hi;
        rst        = 1'b1;
        locked     = 1'b0;
        relock_req = 1'b0;

        // Nominal release: row i holds expected outputs after edge i+1
        nom[0]  = mk(1, 0, 1, 1, 0, 0, 0);
        nom[1]  = mk(1, 0, 1, 1, 0, 0, 0);
        nom[2]  = mk(1, 0, 1, 1, 0, 0, 0);
        nom[3]  = mk(1, 0, 0, 1, 0, 0, 0);
        nom[4]  = mk(1, 0, 0, 1, 0, 0, 0);
        nom[5]  = mk(1, 0, 0, 1, 0, 0, 0);
        nom[6]  = mk(1, 0, 0, 1, 0, 0, 0);
        nom[7]  = mk(1, 0, 0, 1, 0, 0, 0);
        nom[8]  = mk(1, 0, 0, 1, 0, 0, 0);
        nom[9]  = mk(1, 0, 0, 1, 0, 0, 0);
        nom[10] = mk(1, 0, 0, 1, 0, 0, 0);
        nom[11] = mk(1, 0, 0, 1, 0, 0, 0);
        nom[12] = mk(1, 0, 0, 0, 1, 0, 0);
        nom[13] = mk(1, 0, 0, 0, 1, 0, 0);

        // Reset state
        #1;
        chk("rst_pll_rst", pll_rst, 1);
        chk("rst_sys_rst", sys_rst, 1);
        chk("rst_ready", ready, 0);
        chk("rst_timeout_cnt", timeout_cnt, 0);
        chk("rst_loss_cnt", loss_cnt, 0);

        // Nominal table
        do_reset(1'b1);
        for (int i = 0; i < 14; i++) begin
            locked     = nom[i].locked;
            relock_req = nom[i].relock;
            tick();
            chk("nom_pll_rst", pll_rst, nom[i].pll_rst);
            chk("nom_sys_rst", sys_rst, nom[i].sys_rst);
            chk("nom_ready", ready, nom[i].ready);
            chk("nom_timeout_cnt", timeout_cnt, nom[i].tcnt);
            chk("nom_loss_cnt", loss_cnt, nom[i].lcnt);
        end

        // Lock glitch in STABLE: locked low between edges 7 and 8 only
        do_reset(1'b1);
        ticks(7);
        locked = 1'b0;
        tick();
        locked = 1'b1;
        for (int e = 9; e <= 20; e++) begin
            tick();
            chk("glitch_pll_rst", pll_rst, 0);
            chk("glitch_ready", ready, (e >= 19) ? 1 : 0);
            chk("glitch_sys_rst", sys_rst, (e >= 19) ? 0 : 1);
        end
        chk("glitch_loss_cnt", loss_cnt, 0);

        // Timeout: 4-cycle pll_rst pulse every 36 cycles
        do_reset(1'b0);
        for (int e = 1; e <= 110; e++) begin
            tick();
            chk("to_pll_rst", pll_rst, ((e % 36) < 4) ? 1 : 0);
            chk("to_timeout_cnt", timeout_cnt, e / 36);
            chk("to_sys_rst", sys_rst, 1);
        end
        ticks(36 * 254 + 35 - 110);
        chk("to_cnt_254", timeout_cnt, 254);
        tick();
        chk("to_cnt_255", timeout_cnt, 255);
        ticks(36 * 300 - 36 * 255);
        chk("to_cnt_sat", timeout_cnt, 255);
        chk("to_sat_sys_rst", sys_rst, 1);

        // Loss in RUN, then relock and relock_req handling
        do_reset(1'b1);
        ticks(15);
        chk("loss_pre_ready", ready, 1);
        locked = 1'b0;
        ticks(2);
        chk("loss_e17_ready", ready, 1);
        chk("loss_e17_pll_rst", pll_rst, 0);
        tick();
        chk("loss_e18_sys_rst", sys_rst, 1);
        chk("loss_e18_pll_rst", pll_rst, 1);
        chk("loss_e18_ready", ready, 0);
        chk("loss_e18_loss_cnt", loss_cnt, 1);
        locked = 1'b1;
        ticks(11);
        chk("relock_e29_ready", ready, 0);
        ticks(1);
        chk("relock_e30_ready", ready, 0);
        tick();
        chk("relock_e31_ready", ready, 1);
        chk("relock_e31_sys_rst", sys_rst, 0);
        chk("relock_loss_cnt", loss_cnt, 1);

        tick();
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        chk("req_e33_pll_rst", pll_rst, 1);
        chk("req_e33_sys_rst", sys_rst, 1);
        chk("req_e33_ready", ready, 0);
        chk("req_loss_cnt", loss_cnt, 1);
        chk("req_timeout_cnt", timeout_cnt, 0);
        hi = 1;
        tick();
        relock_req = 1'b1;
        hi += pll_rst;
        tick();
        relock_req = 1'b0;
        hi += pll_rst;
        for (int e = 36; e <= 41; e++) begin
            tick();
            chk("req_restart_pll_rst", pll_rst, (e <= 38) ? 1 : 0);
            hi += pll_rst;
        end
        chk("req_pll_rst_high_cycles", hi, 6);

        // Async reset mid-STABLE after two timeouts
        do_reset(1'b0);
        ticks(80);
        chk("ar_pre_timeout_cnt", timeout_cnt, 2);
        locked = 1'b1;
        ticks(5);
        chk("ar_pre_pll_rst", pll_rst, 0);
        chk("ar_pre_sys_rst", sys_rst, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_pll_rst", pll_rst, 1);
        chk("ar_sys_rst", sys_rst, 1);
        chk("ar_ready", ready, 0);
        chk("ar_timeout_cnt", timeout_cnt, 0);
        chk("ar_loss_cnt", loss_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
